// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped UART transmitter. A store to TXD queues a byte in a small
//   FIFO; the serializer drains it as 8N1 frames, LSB first, on tx. The TX
//   half of the UART control/status register (CON) and a transmit-done
//   interrupt request are exposed on the bus.
//
// Ports
//   clk        system clock, all state on posedge
//   reset      asynchronous active-high reset
//   addr       bus byte address (full decode)
//   mem_write  store strobe
//   mem_read   load strobe (drives the CON read-to-clear of tx_done)
//   wdata      store data
//   rdata      combinational read data for addr
//   tx         serial line, idle high, registered
//   irq_tx     tx irq enable AND tx_done
//
// CON layout: [0] tx irq en, [1] rx irq en, [2] tx_done (sticky),
//             [3] 0, [4] busy, [5] overflow (sticky), [31:6] 0
// ---------------------------------------------------------------------------
module uart_tx_periph #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] ADDR_TXD     = 32'h4000_0018,
    parameter logic [31:0] ADDR_CON     = 32'h4000_0020
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq_tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_next;
    logic [BAUD_W-1:0]  baud_cnt, baud_next;
    logic [2:0]         bit_cnt, bit_next;
    logic [7:0]         shifter, shift_next;
    logic               tx_next;
    logic               pop, done_set;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty, fifo_full;

    logic               tx_irq_en, rx_irq_en, tx_done, overflow;
    logic [7:0]         last_txd;

    logic               txd_sel, con_sel;
    logic               push_req, push, overflow_set;
    logic               con_write, con_read;
    logic               busy;
    logic               unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign txd_sel    = (addr == ADDR_TXD);
    assign con_sel    = (addr == ADDR_CON);
    assign con_write  = mem_write & con_sel;
    assign con_read   = mem_read & con_sel;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);

    // A pop in the same cycle frees the slot, so a push to a full FIFO is
    // still accepted when the serializer is taking a byte out.
    assign push_req     = mem_write & txd_sel;
    assign push         = push_req & (~fifo_full | pop);
    assign overflow_set = push_req & fifo_full & ~pop;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    // ---------------- serializer FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            tx       <= tx_next;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shift_next;
    end

    // tx is computed one cycle ahead so the pin is driven straight from a flop.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shifter;
        tx_next    = tx;
        pop        = 1'b0;
        done_set   = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_mem[rd_ptr];
                    state_next = START;
                    baud_next  = '0;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = '0;
                    tx_next    = shifter[0];
                end else begin
                    baud_next  = baud_cnt + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_next = '0;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next   = bit_cnt + 3'd1;
                        shift_next = {1'b0, shifter[7:1]};
                        tx_next    = shifter[1];
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    done_set  = 1'b1;
                    baud_next = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_mem[rd_ptr];
                        state_next = START;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + BAUD_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- control/status register ----------------
    // Set events take priority over clears landing on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            tx_done   <= 1'b0;
            overflow  <= 1'b0;
            last_txd  <= 8'h00;
        end else begin
            if (con_write) begin
                tx_irq_en <= wdata[0];
                rx_irq_en <= wdata[1];
            end
            if (done_set)                    tx_done <= 1'b1;
            else if (con_write || con_read)  tx_done <= 1'b0;
            if (overflow_set)                overflow <= 1'b1;
            else if (con_write)              overflow <= 1'b0;
            if (push_req)                    last_txd <= wdata[7:0];
        end
    end

    assign busy   = (state != IDLE) | ~fifo_empty;
    assign irq_tx = tx_irq_en & tx_done;

    always_comb begin
        rdata = 32'h0;
        if (txd_sel)
            rdata = {24'h0, last_txd};
        else if (con_sel)
            rdata = {26'h0, overflow, busy, 1'b0, tx_done, rx_irq_en, tx_irq_en};
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
//   Self-checking bench for uart_tx_periph with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   A vector table covers register decode and CON read/write behaviour; the
//   frame-level cases are hand-written sequences. Outputs are sampled on the
//   falling edge; "cycle c" of a frame is the falling edge after the c-th
//   rising edge following the one that started it (tx low at c=0).
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam int          CPB      = 4;
    localparam int          FRAME    = 10 * CPB;
    localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] ADDR_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;
    logic        irq_tx;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q [0:7];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [15];

    uart_tx_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (4),
        .ADDR_TXD    (ADDR_TXD),
        .ADDR_CON    (ADDR_CON)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .mem_write(mem_write),
        .mem_read (mem_read),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx       (tx),
        .irq_tx   (irq_tx)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference line level for cycle k (0..FRAME-1) of a frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int slot;
        slot = k / CPB;
        if (slot == 0)      return 1'b0;
        else if (slot <= 8) return b[slot-1];
        else                return 1'b1;
    endfunction

    // Called on a falling edge; performs one store over the next rising edge
    // and returns on the following falling edge with addr parked on CON.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        wdata     = d;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        addr      = ADDR_CON;
        wdata     = 32'h0;
        @(negedge clk);
    endtask

    task automatic bus_read_con();
        addr     = ADDR_CON;
        mem_read = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
    endtask

    // Check tx on frame cycles [from, to) of back-to-back frames in frame_q.
    task automatic watch_tx(input int from, input int to);
        for (int c = from; c < to; c++) begin
            check1($sformatf("tx_c%0d", c), tx, exp_bit(frame_q[c / FRAME], c % FRAME));
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, ADDR_CON,      32'h0,        32'h0,  1'b0};
        vecs[1]  = '{1'b0, 1'b0, ADDR_TXD,      32'h0,        32'h0,  1'b0};
        vecs[2]  = '{1'b0, 1'b0, 32'h4000_001C, 32'h0,        32'h0,  1'b0};
        vecs[3]  = '{1'b1, 1'b0, ADDR_CON,      32'hFFFF_FFFF, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, ADDR_CON,      32'h0,        32'h3,  1'b0};
        vecs[5]  = '{1'b0, 1'b1, ADDR_CON,      32'h0,        32'h3,  1'b0};
        vecs[6]  = '{1'b1, 1'b0, ADDR_CON,      32'h2,        32'h3,  1'b0};
        vecs[7]  = '{1'b0, 1'b0, ADDR_CON,      32'h0,        32'h2,  1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h0,  1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h4000_0021, 32'h0,        32'h0,  1'b0};
        vecs[10] = '{1'b1, 1'b0, ADDR_CON,      32'h0,        32'h2,  1'b0};
        vecs[11] = '{1'b0, 1'b0, ADDR_CON,      32'h0,        32'h0,  1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h4000_0019, 32'h77,       32'h0,  1'b0};
        vecs[13] = '{1'b0, 1'b0, ADDR_CON,      32'h0,        32'h0,  1'b0};
        vecs[14] = '{1'b0, 1'b0, ADDR_TXD,      32'h0,        32'h0,  1'b0};

        reset     = 1'b1;
        addr      = ADDR_CON;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        wdata     = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_tx", tx, 1'b1);
        check32("rst_con", rdata, 32'h0);
        check1("rst_irq", irq_tx, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Register decode table; rdata is the combinational view during the op
        for (int i = 0; i < 15; i++) begin
            addr      = vecs[i].addr;
            wdata     = vecs[i].wdata;
            mem_write = vecs[i].we;
            mem_read  = vecs[i].re;
            #1;
            check32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check1($sformatf("vec%0d_irq", i), irq_tx, vecs[i].exp_irq);
            @(posedge clk);
            #1;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            addr      = ADDR_CON;
            wdata     = 32'h0;
            @(negedge clk);
        end

        // Single frame of 0x55, irq disabled
        bus_write(ADDR_TXD, 32'h55);
        check1("t1_pre_tx", tx, 1'b1);
        check32("t1_busy", rdata, 32'h10);
        @(negedge clk);
        frame_q[0] = 8'h55;
        watch_tx(0, FRAME - 1);
        check1("t1_stop_tx", tx, 1'b1);
        check1("t1_done_early", rdata[2], 1'b0);
        @(negedge clk);
        check32("t1_con_done", rdata, 32'h04);
        check1("t1_irq", irq_tx, 1'b0);

        // Interrupt enabled, read-to-clear
        bus_write(ADDR_CON, 32'h3);
        check32("t2_con_cleared", rdata, 32'h03);
        bus_write(ADDR_TXD, 32'hA3);
        check1("t2_pre_tx", tx, 1'b1);
        @(negedge clk);
        frame_q[0] = 8'hA3;
        watch_tx(0, FRAME - 1);
        check1("t2_irq_early", irq_tx, 1'b0);
        @(negedge clk);
        check1("t2_irq", irq_tx, 1'b1);
        mem_read = 1'b1;
        #1;
        check32("t2_load_con", rdata, 32'h07);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        check32("t2_after_load", rdata, 32'h03);
        check1("t2_irq_clear", irq_tx, 1'b0);

        // Done-set coincides with a CON load
        bus_write(ADDR_TXD, 32'h3C);
        @(negedge clk);
        frame_q[0] = 8'h3C;
        watch_tx(0, FRAME - 1);
        mem_read = 1'b1;
        #1;
        check32("t4_load_during", rdata, 32'h13);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        @(negedge clk);
        check32("t4_done_wins_read", rdata, 32'h07);
        check1("t4_irq", irq_tx, 1'b1);
        bus_read_con();
        check32("t4_cleared", rdata, 32'h03);

        // Done-set coincides with a CON store
        bus_write(ADDR_TXD, 32'h81);
        @(negedge clk);
        frame_q[0] = 8'h81;
        watch_tx(0, FRAME - 1);
        bus_write(ADDR_CON, 32'h3);
        check32("t4_done_wins_write", rdata, 32'h07);
        bus_write(ADDR_CON, 32'h0);
        check32("t4_con_zero", rdata, 32'h0);

        // Burst of six stores: four queued, one in flight, sixth dropped
        for (int i = 0; i < 6; i++) bus_write(ADDR_TXD, 32'(i + 1));
        check32("t3_overflow", rdata, 32'h30);
        for (int i = 0; i < 5; i++) frame_q[i] = 8'(i + 1);
        watch_tx(4, 5 * FRAME);
        check32("t3_end_con", rdata, 32'h24);
        for (int i = 0; i < 8; i++) begin
            check1($sformatf("t3_idle_tx%0d", i), tx, 1'b1);
            @(negedge clk);
        end
        check32("t3_idle_con", rdata, 32'h24);

        // Reset in the middle of data bit 3 of 0xF0 with bytes queued behind it
        bus_write(ADDR_TXD, 32'hF0);
        bus_write(ADDR_TXD, 32'h11);
        bus_write(ADDR_TXD, 32'h22);
        frame_q[0] = 8'hF0;
        watch_tx(1, 17);
        check1("t5_pre_tx", tx, 1'b0);
        reset = 1'b1;
        #1;
        check1("t5_async_tx", tx, 1'b1);
        check32("t5_async_con", rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check1($sformatf("t5_quiet_tx%0d", i), tx, 1'b1);
        end
        check32("t5_quiet_con", rdata, 32'h0);
        bus_write(ADDR_TXD, 32'h5A);
        check1("t5_pre2_tx", tx, 1'b1);
        @(negedge clk);
        frame_q[0] = 8'h5A;
        watch_tx(0, FRAME);
        check32("t5_con", rdata, 32'h04);

        // Upper store bits ignored; CON store mid-frame leaves the frame intact
        bus_write(ADDR_TXD, 32'hDEAD_BE12);
        addr = ADDR_TXD;
        #1;
        check32("t6_txd_read", rdata, 32'h12);
        addr = 32'h4000_001C;
        #1;
        check32("t6_gap_read", rdata, 32'h0);
        addr = ADDR_CON;
        check1("t6_pre_tx", tx, 1'b1);
        @(negedge clk);
        frame_q[0] = 8'h12;
        watch_tx(0, 10);
        bus_write(ADDR_CON, 32'h1);
        watch_tx(11, FRAME);
        check32("t6_con", rdata, 32'h05);
        check1("t6_irq", irq_tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
